// File: rtl/crc_frame_arbiter.sv
// Two-requester round-robin arbiter feeding a bit-serial CRC engine (MSB first).
// Define CRC_ARB_STATS_EN to add per-requester saturating handshake counters cnt0/cnt1.
module crc_frame_arbiter #(
    parameter int              MSG_W = 10,
    parameter int              CRC_W = 9,
    parameter logic [CRC_W-1:0] POLY = 9'h003
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [MSG_W-1:0] msg0,
    input  logic [MSG_W-1:0] msg1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CRC_W-1:0] out_crc,
    output logic             out_id
`ifdef CRC_ARB_STATS_EN
    ,
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1
`endif
);

    localparam int CNT_W = $clog2(MSG_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [MSG_W-1:0]   msg_q, msg_d;
    logic [CRC_W-1:0]   crc_q, crc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               id_q, id_d;
    logic               last_q, last_d;
    logic               fb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            msg_q   <= '0;
            crc_q   <= '0;
            cnt_q   <= '0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    // last_q names the requester served most recently; on a tie the other one wins.
    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        last_d  = last_q;
        gnt     = 2'b00;
        fb      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!reset) begin
                    if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
                    else              gnt = req;
                end
                if (|gnt) begin
                    state_d = SHIFT;
                    msg_d   = gnt[1] ? msg1 : msg0;
                    crc_d   = '0;
                    cnt_d   = '0;
                    id_d    = gnt[1];
                    last_d  = gnt[1];
                end
            end
            SHIFT: begin
                fb    = msg_q[MSG_W-1] ^ crc_q[CRC_W-1];
                crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
                msg_d = {msg_q[MSG_W-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(MSG_W - 1)) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign out_crc   = crc_q;
    assign out_id    = id_q;

`ifdef CRC_ARB_STATS_EN
    logic [7:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (out_valid && out_ready) begin
            if (!id_q && cnt0_q != 8'hFF) cnt0_q <= cnt0_q + 8'd1;
            if (id_q && cnt1_q != 8'hFF)  cnt1_q <= cnt1_q + 8'd1;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_crc_frame_arbiter.sv
// Randomized self-checking bench for crc_frame_arbiter; the CRC reference is
// polynomial long division of msg*x^CRC_W by the full generator.
module tb_crc_frame_arbiter;

    localparam int             MSG_W = 10;
    localparam int             CRC_W = 9;
    localparam logic [CRC_W:0] GEN   = 10'h203;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req;
    logic [MSG_W-1:0] msg0, msg1;
    logic [1:0]       gnt;
    logic             busy, out_valid, out_ready, out_id;
    logic [CRC_W-1:0] out_crc;
`ifdef CRC_ARB_STATS_EN
    logic [7:0]       cnt0, cnt1;
`endif

    int checks = 0;
    int errors = 0;
    int lastServed = 1;
    int served0 = 0;
    int served1 = 0;

    crc_frame_arbiter dut (
        .clk(clk), .reset(reset), .req(req), .msg0(msg0), .msg1(msg1),
        .gnt(gnt), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_crc(out_crc), .out_id(out_id)
`ifdef CRC_ARB_STATS_EN
        , .cnt0(cnt0), .cnt1(cnt1)
`endif
    );

    always #5 clk = ~clk;

    // Remainder of M(x)*x^CRC_W divided by the generator, computed by long division.
    function automatic logic [CRC_W-1:0] refCrc(input logic [MSG_W-1:0] m);
        logic [MSG_W+CRC_W-1:0] d;
        logic [MSG_W+CRC_W-1:0] g;
        d = {m, {CRC_W{1'b0}}};
        for (int i = MSG_W + CRC_W - 1; i >= CRC_W; i--) begin
            if (d[i]) begin
                g = (MSG_W+CRC_W)'(GEN);
                d = d ^ (g << (i - CRC_W));
            end
        end
        return d[CRC_W-1:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkStats();
`ifdef CRC_ARB_STATS_EN
        checkOutput("cnt0", cnt0, (served0 > 255) ? 255 : served0);
        checkOutput("cnt1", cnt1, (served1 > 255) ? 255 : served1);
`endif
    endtask

    // One complete frame: request, grant, serial phase with noise on req/out_ready, stall, handshake.
    task automatic applyStimulus(input logic [1:0] r, input logic [MSG_W-1:0] m0,
                                 input logic [MSG_W-1:0] m1, input int stall);
        int               win;
        int               cycles;
        logic [MSG_W-1:0] m;
        logic [CRC_W-1:0] expCrc;
        req = r; msg0 = m0; msg1 = m1; out_ready = 1'b0;
        #1;
        if (r == 2'b01)      win = 0;
        else if (r == 2'b10) win = 1;
        else                 win = (lastServed == 0) ? 1 : 0;
        checkOutput("gnt", gnt, (win == 1) ? 2'b10 : 2'b01);
        checkOutput("busyIdle", busy, 0);
        @(posedge clk); #1;
        lastServed = win;
        m = (win == 1) ? m1 : m0;
        expCrc = refCrc(m);
        checkOutput("busyShift", busy, 1);
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < 40) begin
            req = 2'($urandom); out_ready = 1'($urandom);
            msg0 = MSG_W'($urandom); msg1 = MSG_W'($urandom);
            @(posedge clk); #1;
            cycles++;
            checkOutput("gntBusy", gnt, 0);
        end
        checkOutput("latency", cycles, MSG_W);
        out_ready = 1'b0;
        for (int k = 0; k < stall; k++) begin
            checkOutput("stallValid", out_valid, 1);
            checkOutput("stallCrc", out_crc, expCrc);
            checkOutput("stallId", out_id, win);
            req = 2'($urandom);
            @(posedge clk); #1;
            checkOutput("gntDone", gnt, 0);
        end
        checkOutput("valid", out_valid, 1);
        checkOutput("crc", out_crc, expCrc);
        checkOutput("id", out_id, win);
        out_ready = 1'b1;
        @(posedge clk); #1;
        if (win == 0) served0++; else served1++;
        checkOutput("validAfter", out_valid, 0);
        checkOutput("busyAfter", busy, 0);
        checkStats();
        req = 2'b00; out_ready = 1'b0;
    endtask

    initial begin
        int sawValid;
        logic [1:0] r;
        reset = 1'b1; req = 2'b11; msg0 = '0; msg1 = '0; out_ready = 1'b1;
        #12;
        checkOutput("rstGnt", gnt, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstValid", out_valid, 0);
        checkOutput("rstCrc", out_crc, 0);
        checkOutput("rstId", out_id, 0);
        checkStats();
        req = 2'b00; out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        applyStimulus(2'b01, 10'h001, 10'h155, 0);
        checkOutput("crc001", refCrc(10'h001), 9'h003);
        applyStimulus(2'b10, 10'h0AA, 10'h200, 0);
        applyStimulus(2'b11, 10'h000, 10'h000, 0);
        applyStimulus(2'b11, 10'h000, 10'h000, 1);
        applyStimulus(2'b11, 10'h000, 10'h000, 2);
        applyStimulus(2'b01, 10'h3FF, 10'h123, 5);

        for (int i = 0; i < 40; i++) begin
            r = 2'($urandom_range(1, 3));
            applyStimulus(r, MSG_W'($urandom), MSG_W'($urandom), int'($urandom_range(0, 4)));
        end

        // Abort a frame mid-SHIFT; it must never produce a result.
        req = 2'b01; msg0 = 10'h3A5; out_ready = 1'b0;
        @(posedge clk); #1;
        req = 2'b00;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstValid", out_valid, 0);
        checkOutput("midRstCrc", out_crc, 0);
        reset = 1'b0;
        lastServed = 1; served0 = 0; served1 = 0;
        checkStats();
        out_ready = 1'b1;
        sawValid = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid) sawValid = 1;
        end
        checkOutput("noValidAfterRst", sawValid, 0);
        applyStimulus(2'b11, 10'h001, MSG_W'($urandom), 0);

`ifdef CRC_ARB_STATS_EN
        for (int i = 0; i < 300; i++) applyStimulus(2'b01, MSG_W'($urandom), 10'h000, 0);
        checkOutput("sat0", cnt0, 255);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc_frame_arbiter.md
CRC_FRAME_ARBITER -- requirements
Module: crc_frame_arbiter

Interface
REQ-001 The block SHALL have parameter MSG_W, default 10, message width in bits.
REQ-002 The block SHALL have parameter CRC_W, default 9, CRC register width.
REQ-003 The block SHALL have parameter POLY, default 9'h003 (x^9+x+1), low CRC_W bits of the generator.
REQ-004 The block SHALL use clock clk, and reset reset, asynchronous, active-high.
REQ-005 Ports SHALL be:
- clk  in  1  clock
- reset  in  1  async reset
- req  in  2  per-requester frame request, held until granted
- msg0  in  MSG_W  requester 0 message
- msg1  in  MSG_W  requester 1 message
- gnt  out  2  one-hot grant, combinational
- busy  out  1  engine occupied (state not IDLE)
- out_valid  out  1  result valid
- out_ready  in  1  result consumer ready
- out_crc  out  CRC_W  computed CRC
- out_id  out  1  requester index of result

Function
REQ-006 The FSM SHALL have states IDLE, SHIFT, DONE.
REQ-007 In IDLE with any req bit set, gnt SHALL be one-hot for the selected requester; otherwise gnt SHALL be 0. gnt SHALL be 0 outside IDLE.
REQ-008 Selection SHALL be round-robin: on a single request, grant it; on both, grant the requester not served last. The priority pointer SHALL reset to favour requester 0.
REQ-009 On the edge with req[i]&gnt[i], the block SHALL capture msg_i, clear CRC to 0, clear the bit counter, record out_id=i, and enter SHIFT.
REQ-010 SHIFT SHALL process one message bit per cycle, MSB first: fb = bit ^ crc[CRC_W-1]; crc_next = {crc[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0).
REQ-011 SHIFT SHALL last exactly MSG_W cycles, then enter DONE; out_valid SHALL rise MSG_W cycles after the capture edge.
REQ-012 In DONE, out_valid=1, and out_crc and out_id SHALL hold stable until out_valid&out_ready.
REQ-013 On out_valid&out_ready, the block SHALL enter IDLE; a pending req SHALL be granted no earlier than the following cycle (no same-cycle bypass).
REQ-014 out_ready SHALL be ignored outside DONE; req changes during SHIFT/DONE SHALL NOT affect the current frame.
REQ-015 The bit counter SHALL be wide enough for MSG_W and SHALL NOT wrap within a frame.

Reset
REQ-016 Reset SHALL force IDLE; out_valid=0, out_crc=0, out_id=0, gnt=0, busy=0, counter=0, priority to requester 0.
REQ-017 Reset asserted mid-SHIFT or mid-DONE SHALL discard the frame; no out_valid SHALL appear for it.

Configuration
REQ-018 With macro CRC_ARB_STATS_EN defined, the block SHALL add outputs cnt0 and cnt1 (8 bits each), counting completed result handshakes per requester, saturating at 255, reset to 0.
REQ-019 Without CRC_ARB_STATS_EN, cnt0/cnt1 and their logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-020 req=2'b01, msg0=10'h001, out_ready=1 -> gnt=2'b01 one cycle, out_valid 10 cycles after capture, out_crc=9'h003, out_id=0.
REQ-021 req=2'b10, msg1=10'h200 -> out_crc=9'h005, out_id=1.
REQ-022 req=2'b11 held across three frames -> grant order 0,1,0; msg all zero gives out_crc=9'h000.
REQ-023 out_ready=0 for 5 cycles in DONE -> out_valid, out_crc, out_id stable; new req not granted until cycle after handshake.
REQ-024 Reset pulse at SHIFT cycle 4 -> IDLE, out_valid never asserts for that frame, next frame 10'h001 yields 9'h003.
REQ-025 With CRC_ARB_STATS_EN: 300 frames from requester 0 -> cnt0=255, cnt1=0.
